// File: rtl/cloud_pkg.sv
// Shared constants and types for the cloud sprite renderer: sprite geometry,
// screen size, the 2-bit palette and the default sprite image.
package cloud_pkg;

  localparam int SPRITE_W    = 64;
  localparam int SPRITE_H    = 32;
  localparam int SCALE_SHIFT = 1;
  localparam int H_VISIBLE   = 640;
  localparam int V_VISIBLE   = 480;

  localparam int U_BITS    = $clog2(SPRITE_W);
  localparam int V_BITS    = $clog2(SPRITE_H);
  localparam int ROM_DEPTH = SPRITE_W * SPRITE_H;
  localparam int ROM_AW    = $clog2(ROM_DEPTH);

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Index 0 is transparent; its colour is never shown.
  localparam rgb_t PALETTE [4] = '{
    '{8'd0,   8'd0,   8'd0},
    '{8'd200, 8'd200, 8'd210},
    '{8'd230, 8'd230, 8'd240},
    '{8'd255, 8'd255, 8'd255}
  };

  // Banded cloud texture; clear_origin makes texel (0,0) transparent.
  function automatic logic [2*ROM_DEPTH-1:0] sprite_image(input logic clear_origin);
    logic [2*ROM_DEPTH-1:0] img;
    logic [1:0]             idx;
    img = '0;
    for (int v = 0; v < SPRITE_H; v++) begin
      for (int u = 0; u < SPRITE_W; u++) begin
        idx = 2'd3 - 2'((u >> 3) ^ (v >> 2));
        img[2*(v*SPRITE_W + u) +: 2] = idx;
      end
    end
    if (clear_origin) begin
      img[1:0] = 2'b00;
    end
    return img;
  endfunction

endpackage

// File: rtl/cloud_renderer_if.sv
// Pixel-stream bundle between the VGA/motion side (master) and the cloud
// renderer (slave).
interface cloud_renderer_if;

  logic       VGA_VS;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [9:0] CloudX;
  logic [9:0] CloudY;
  logic [9:0] CloudS;
  logic       cloud_on;
  logic [7:0] cloud_R;
  logic [7:0] cloud_G;
  logic [7:0] cloud_B;

  modport master (
    output VGA_VS, DrawX, DrawY, CloudX, CloudY, CloudS,
    input  cloud_on, cloud_R, cloud_G, cloud_B
  );

  modport slave (
    input  VGA_VS, DrawX, DrawY, CloudX, CloudY, CloudS,
    output cloud_on, cloud_R, cloud_G, cloud_B
  );

endinterface

// File: rtl/cloud_rom.sv
// Synchronous single-port sprite ROM, 2-bit palette index per texel, one
// cycle read latency. Contents come from the IMAGE parameter.
module cloud_rom
  import cloud_pkg::*;
#(
  parameter logic [2*ROM_DEPTH-1:0] IMAGE = sprite_image(1'b0)
) (
  input  logic              Clk,
  input  logic [ROM_AW-1:0] addr,
  output logic [1:0]        data
);

  logic [1:0] rom [ROM_DEPTH];

  generate
    for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_init
      assign rom[gi] = IMAGE[2*gi +: 2];
    end
  endgenerate

  always_ff @(posedge Clk) begin
    data <= rom[addr];
  end

endmodule

// File: rtl/cloud_renderer.sv
// Cloud sprite layer: latches the cloud position once per frame on VGA_VS
// fall, then maps each pixel into a scaled sprite ROM with 3-cycle latency.
module cloud_renderer
  import cloud_pkg::*;
#(
  parameter logic [2*ROM_DEPTH-1:0] ROM_IMAGE = sprite_image(1'b0)
) (
  input  logic             Clk,
  input  logic             Reset,
  cloud_renderer_if.slave  bus
);

  localparam int SPAN_W = SPRITE_W << SCALE_SHIFT;
  localparam int SPAN_H = SPRITE_H << SCALE_SHIFT;

  logic       vs_d;
  logic [9:0] lx;
  logic [9:0] ly;
  logic [9:0] ls;

  // Position only moves at the start of vsync, so a frame never tears.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vs_d <= 1'b1;
      lx   <= '0;
      ly   <= '0;
      ls   <= '0;
    end else begin
      vs_d <= bus.VGA_VS;
      if (vs_d && !bus.VGA_VS) begin
        lx <= bus.CloudX;
        ly <= bus.CloudY;
        ls <= bus.CloudS;
      end
    end
  end

  logic [9:0] dx;
  logic [9:0] dy;
  logic       hit_comb;

  // Modular differences give the left-edge wrap for lx near 1023 for free.
  assign dx = bus.DrawX - lx;
  assign dy = bus.DrawY - ly;
  assign hit_comb = (bus.DrawX < 10'(H_VISIBLE)) && (bus.DrawY < 10'(V_VISIBLE))
                 && (dx < 10'(SPAN_W)) && (dx < ls) && (dy < 10'(SPAN_H));

  logic [U_BITS-1:0] u_reg;
  logic [V_BITS-1:0] v_reg;
  logic              hit0;
  logic              hit1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      u_reg <= '0;
      v_reg <= '0;
      hit0  <= 1'b0;
      hit1  <= 1'b0;
    end else begin
      u_reg <= dx[SCALE_SHIFT +: U_BITS];
      v_reg <= dy[SCALE_SHIFT +: V_BITS];
      hit0  <= hit_comb;
      hit1  <= hit0;
    end
  end

  logic [1:0] rom_data;

  cloud_rom #(
    .IMAGE (ROM_IMAGE)
  ) u_rom (
    .Clk  (Clk),
    .addr ({v_reg, u_reg}),
    .data (rom_data)
  );

  logic opaque;
  rgb_t texel_rgb;
  logic on_reg;
  rgb_t rgb_reg;

  assign opaque    = hit1 && (rom_data != 2'd0);
  assign texel_rgb = PALETTE[rom_data];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      on_reg  <= 1'b0;
      rgb_reg <= '0;
    end else begin
      on_reg  <= opaque;
      rgb_reg <= opaque ? texel_rgb : '0;
    end
  end

  assign bus.cloud_on = on_reg;
  assign bus.cloud_R  = rgb_reg.r;
  assign bus.cloud_G  = rgb_reg.g;
  assign bus.cloud_B  = rgb_reg.b;

endmodule
